// File: rtl/sorted_insert.sv
// sorted_insert: keeps a 32x8 RAM array sorted ascending by shifting larger entries up on each insert
module sorted_insert #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 5,
    parameter int DEPTH      = 32
) (
    input  logic                  clk_i,
    input  logic                  reset_ni,
    input  logic                  start_i,
    input  logic                  clear_i,
    input  logic [DATA_WIDTH-1:0] a_i,
    output logic [ADDR_WIDTH-1:0] rd_addr_o,
    input  logic [DATA_WIDTH-1:0] rdata_i,
    output logic [ADDR_WIDTH-1:0] wr_addr_o,
    output logic [DATA_WIDTH-1:0] wdata_o,
    output logic                  wren_o,
    output logic [ADDR_WIDTH:0]   count_o,
    output logic                  done_o,
    output logic                  full_o,
    output logic                  rejected_o
);
    typedef enum logic [2:0] {IDLE, RD, CMP, PLACE, DONE} state_t;

    state_t                state_q;
    logic [DATA_WIDTH-1:0] a_q;
    logic [ADDR_WIDTH-1:0] i_q;
    logic [ADDR_WIDTH-1:0] pos_q;
    logic [ADDR_WIDTH:0]   count_q;
    logic [ADDR_WIDTH-1:0] rd_addr_q;
    logic [ADDR_WIDTH-1:0] wr_addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic                  wren_q;
    logic                  done_q;
    logic                  rejected_q;
    logic                  full;

    assign full       = count_q == (ADDR_WIDTH+1)'(DEPTH);
    assign full_o     = full;
    assign count_o    = count_q;
    assign rd_addr_o  = rd_addr_q;
    assign wr_addr_o  = wr_addr_q;
    assign wdata_o    = wdata_q;
    assign wren_o     = wren_q;
    assign done_o     = done_q;
    assign rejected_o = rejected_q;

    // Insert FSM: scans down from the top entry, shifting each larger value up one slot,
    // then drops the new value into the gap. rd_addr is loaded on entry to RD so the
    // synchronous RAM presents mem[i] during CMP.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q    <= IDLE;
            a_q        <= '0;
            i_q        <= '0;
            pos_q      <= '0;
            count_q    <= '0;
            rd_addr_q  <= '0;
            wr_addr_q  <= '0;
            wdata_q    <= '0;
            wren_q     <= 1'b0;
            done_q     <= 1'b0;
            rejected_q <= 1'b0;
        end else begin
            wren_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (clear_i) begin
                        count_q <= '0;
                    end else if (start_i) begin
                        if (full) begin
                            rejected_q <= 1'b1;
                            done_q     <= 1'b1;
                            state_q    <= DONE;
                        end else begin
                            a_q        <= a_i;
                            rejected_q <= 1'b0;
                            if (count_q == '0) begin
                                pos_q   <= '0;
                                state_q <= PLACE;
                            end else begin
                                i_q       <= ADDR_WIDTH'(count_q - 1'b1);
                                rd_addr_q <= ADDR_WIDTH'(count_q - 1'b1);
                                state_q   <= RD;
                            end
                        end
                    end
                end
                RD: state_q <= CMP;
                CMP: begin
                    if (rdata_i > a_q) begin
                        wren_q    <= 1'b1;
                        wr_addr_q <= i_q + 1'b1;
                        wdata_q   <= rdata_i;
                        if (i_q == '0) begin
                            pos_q   <= '0;
                            state_q <= PLACE;
                        end else begin
                            i_q       <= i_q - 1'b1;
                            rd_addr_q <= i_q - 1'b1;
                            state_q   <= RD;
                        end
                    end else begin
                        pos_q   <= i_q + 1'b1;
                        state_q <= PLACE;
                    end
                end
                PLACE: begin
                    wren_q    <= 1'b1;
                    wr_addr_q <= pos_q;
                    wdata_q   <= a_q;
                    count_q   <= count_q + 1'b1;
                    done_q    <= 1'b1;
                    state_q   <= DONE;
                end
                DONE: begin
                    if (!start_i) begin
                        done_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sorted_insert.sv
// tb_sorted_insert: directed checks of sorted_insert against a behavioural synchronous RAM
module tb_sorted_insert;
    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        start = 1'b0;
    logic        clear = 1'b0;
    logic [7:0]  a = '0;
    logic [7:0]  rdata;
    logic [4:0]  rd_addr;
    logic [4:0]  wr_addr;
    logic [7:0]  wdata;
    logic        wren;
    logic [5:0]  count;
    logic        done;
    logic        full;
    logic        rejected;
    logic [7:0]  mem [32];
    logic [12:0] wlog [$];
    int          checks = 0;
    int          failures = 0;
    int          lat;

    always #5 clk = ~clk;

    sorted_insert dut (
        .clk_i(clk), .reset_ni(reset_n), .start_i(start), .clear_i(clear), .a_i(a),
        .rd_addr_o(rd_addr), .rdata_i(rdata), .wr_addr_o(wr_addr), .wdata_o(wdata),
        .wren_o(wren), .count_o(count), .done_o(done), .full_o(full), .rejected_o(rejected)
    );

    // Dual-port RAM with one-cycle read latency; every write is also logged
    always @(posedge clk) begin
        if (wren) begin
            mem[wr_addr] <= wdata;
            wlog.push_back({wr_addr, wdata});
        end
        rdata <= mem[rd_addr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic ins(input logic [7:0] v);
        @(negedge clk);
        wlog.delete();
        a = v;
        start = 1'b1;
        @(posedge clk);
        lat = 0;
        for (int n = 0; n < 200; n++) begin
            @(posedge clk);
            #1;
            lat++;
            if (done) break;
        end
        chk("done_seen", done, 1);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
    endtask

    initial begin
        foreach (mem[j]) mem[j] = '0;
        #1 reset_n = 1'b0;
        #2;
        chk("rst_count", count, 0);
        chk("rst_done", done, 0);
        chk("rst_rejected", rejected, 0);
        chk("rst_wren", wren, 0);
        chk("rst_rd_addr", rd_addr, 0);
        chk("rst_wr_addr", wr_addr, 0);
        chk("rst_wdata", wdata, 0);
        chk("rst_full", full, 0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        ins(8'h40);
        chk("empty_nwr", wlog.size(), 1);
        chk("empty_wr", wlog[0], {5'd0, 8'h40});
        chk("empty_count", count, 1);
        chk("empty_rd_addr", rd_addr, 0);

        clr();
        ins(8'd10);
        ins(8'd30);
        chk("lat_30", lat, 3);
        ins(8'd20);
        chk("lat_20", lat, 5);
        chk("ins20_nwr", wlog.size(), 2);
        chk("ins20_shift", wlog[0], {5'd2, 8'd30});
        chk("ins20_place", wlog[1], {5'd1, 8'd20});
        chk("ins20_count", count, 3);
        chk("m3_0", mem[0], 10);
        chk("m3_1", mem[1], 20);
        chk("m3_2", mem[2], 30);

        ins(8'd5);
        chk("lat_5", lat, 7);
        chk("ins5_nwr", wlog.size(), 4);
        chk("ins5_w0", wlog[0], {5'd3, 8'd30});
        chk("ins5_w1", wlog[1], {5'd2, 8'd20});
        chk("ins5_w2", wlog[2], {5'd1, 8'd10});
        chk("ins5_w3", wlog[3], {5'd0, 8'd5});
        chk("ins5_m0", mem[0], 5);
        chk("ins5_m3", mem[3], 30);
        chk("ins5_count", count, 4);

        clr();
        chk("clr_count", count, 0);
        ins(8'd10);
        ins(8'd20);
        ins(8'd30);
        ins(8'd20);
        chk("dup_lat", lat, 5);
        chk("dup_nwr", wlog.size(), 2);
        chk("dup_shift", wlog[0], {5'd3, 8'd30});
        chk("dup_place", wlog[1], {5'd2, 8'd20});
        chk("dup_m1", mem[1], 20);
        chk("dup_m2", mem[2], 20);
        chk("dup_m3", mem[3], 30);

        clr();
        for (int j = 0; j < 32; j++) ins(8'(j * 3 + 2));
        chk("fill_count", count, 32);
        chk("fill_full", full, 1);
        chk("fill_m31", mem[31], 95);
        ins(8'h01);
        chk("rej_flag", rejected, 1);
        chk("rej_nwr", wlog.size(), 0);
        chk("rej_count", count, 32);
        chk("rej_m0", mem[0], 2);
        clr();
        chk("rej_clr_count", count, 0);
        chk("rej_clr_full", full, 0);
        ins(8'h55);
        chk("rej_cleared", rejected, 0);
        chk("after_rej_count", count, 1);

        clr();
        for (int j = 0; j < 10; j++) ins(8'(j * 10 + 20));
        @(negedge clk);
        wlog.delete();
        a = 8'h01;
        start = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        chk("mid_wren", wren, 1);
        chk("mid_wr_addr", wr_addr, 10);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_count", count, 0);
        chk("mid_rst_wren", wren, 0);
        chk("mid_rst_rd_addr", rd_addr, 0);
        chk("mid_rst_wr_addr", wr_addr, 0);
        chk("mid_rst_wdata", wdata, 0);
        chk("mid_rst_done", done, 0);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        ins(8'h77);
        chk("post_rst_nwr", wlog.size(), 1);
        chk("post_rst_wr", wlog[0], {5'd0, 8'h77});
        chk("post_rst_count", count, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
